// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg
//   Shared definitions for the APB timer controller: register offsets,
//   CTRL/STATUS bit positions, the sequencing FSM encoding and the
//   saturating expiry-counter helper.
package apb_timer_pkg;

  // Word-aligned register offsets (byte addresses)
  localparam logic [31:0] OFF_CTRL   = 32'h0;
  localparam logic [31:0] OFF_LOAD   = 32'h4;
  localparam logic [31:0] OFF_COUNT  = 32'h8;
  localparam logic [31:0] OFF_STATUS = 32'hC;

  // CTRL bit positions
  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;

  // STATUS bit positions
  localparam int STAT_DONE_BIT    = 0;
  localparam int STAT_EXP_LSB     = 8;
  localparam int STAT_EXP_CLR_BIT = 31;

  // Expiry counter width and saturation value
  localparam int               EXP_W       = 8;
  localparam logic [EXP_W-1:0] EXP_CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_RUN    = 2'd2,
    ST_RELOAD = 2'd3
  } tmr_state_e;

  // Clear is applied first so that a clear and an expiry on the same edge
  // leave the count at one; the increment sticks at the saturation value.
  function automatic logic [EXP_W-1:0] exp_cnt_next(input logic [EXP_W-1:0] cur,
                                                    input logic             clr,
                                                    input logic             inc);
    logic [EXP_W-1:0] base;
    base = clr ? '0 : cur;
    if (inc && (base != EXP_CNT_MAX)) begin
      base = base + 8'd1;
    end
    return base;
  endfunction

endpackage

// File: rtl/apb_timer_regfile.sv
// apb_timer_regfile
//   APB3 slave decode and register storage for the timer controller.
//   Ports:
//     clk, reset (async, active-low)
//     psel/penable/pwrite/paddr/pwdata  - APB3 request
//     prdata/pready/pslverr             - APB3 response (prdata/pslverr registered
//                                         at the setup-phase edge)
//     cnt_count                         - live counter value, mirrored by COUNT
//     set_done/inc_exp/clr_en           - status updates from the sequencing FSM
//     ctrl_periodic/ctrl_irq_en         - CTRL fields
//     load_val                          - LOAD register
//     done                              - STATUS.DONE
//     wr_en_set/wr_en_clr               - a CTRL write committing this edge with EN=1 / EN=0
module apb_timer_regfile #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [CNT_W-1:0]  cnt_count,
  input  logic              set_done,
  input  logic              inc_exp,
  input  logic              clr_en,
  output logic              ctrl_periodic,
  output logic              ctrl_irq_en,
  output logic [CNT_W-1:0]  load_val,
  output logic              done,
  output logic              wr_en_set,
  output logic              wr_en_clr
);
  import apb_timer_pkg::*;

  logic [31:0]      addr32;
  logic             setup_ph;
  logic             access_ph;
  logic             addr_err;
  logic             wr_err;
  logic             wr_ok;
  logic             wr_ctrl;
  logic             wr_load;
  logic             wr_status;
  logic [31:0]      rdata;

  logic             ctrl_en_q, ctrl_en_d;
  logic             ctrl_per_q, ctrl_per_d;
  logic             ctrl_irq_q, ctrl_irq_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic             done_q, done_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [31:0]      prdata_q, prdata_d;
  logic             pslverr_q, pslverr_d;

  // Only a handful of write-data bits are meaningful
  logic unused_pwdata;
  assign unused_pwdata = ^pwdata;

  always_comb begin
    addr32    = 32'(paddr);
    setup_ph  = psel && !penable;
    access_ph = psel && penable;
    addr_err  = (addr32[1:0] != 2'b00) || (addr32 > OFF_STATUS);
    wr_err    = addr_err || (addr32 == OFF_COUNT);
    wr_ok     = access_ph && pwrite && !wr_err;
    wr_ctrl   = wr_ok && (addr32 == OFF_CTRL);
    wr_load   = wr_ok && (addr32 == OFF_LOAD);
    wr_status = wr_ok && (addr32 == OFF_STATUS);

    wr_en_set = wr_ctrl && pwdata[CTRL_EN_BIT];
    wr_en_clr = wr_ctrl && !pwdata[CTRL_EN_BIT];

    ctrl_en_d  = ctrl_en_q;
    ctrl_per_d = ctrl_per_q;
    ctrl_irq_d = ctrl_irq_q;
    if (wr_ctrl) begin
      ctrl_en_d  = pwdata[CTRL_EN_BIT];
      ctrl_per_d = pwdata[CTRL_PERIODIC_BIT];
      ctrl_irq_d = pwdata[CTRL_IRQ_EN_BIT];
    end
    // FSM-driven clear (one-shot expiry or zero LOAD) overrides the write
    if (clr_en) begin
      ctrl_en_d = 1'b0;
    end

    load_d = load_q;
    if (wr_load) begin
      load_d = pwdata[CNT_W-1:0];
    end

    // A new expiry wins over a simultaneous write-1-to-clear
    done_d = done_q;
    if (wr_status && pwdata[STAT_DONE_BIT]) begin
      done_d = 1'b0;
    end
    if (set_done) begin
      done_d = 1'b1;
    end

    exp_d = exp_cnt_next(exp_q, wr_status && pwdata[STAT_EXP_CLR_BIT], inc_exp);

    rdata = '0;
    case (addr32)
      OFF_CTRL: begin
        rdata[CTRL_EN_BIT]       = ctrl_en_q;
        rdata[CTRL_PERIODIC_BIT] = ctrl_per_q;
        rdata[CTRL_IRQ_EN_BIT]   = ctrl_irq_q;
      end
      OFF_LOAD:  rdata = 32'(load_q);
      OFF_COUNT: rdata = 32'(cnt_count);
      OFF_STATUS: begin
        rdata[STAT_DONE_BIT]              = done_q;
        rdata[STAT_EXP_LSB +: EXP_W]      = exp_q;
      end
      default: rdata = '0;
    endcase

    // Response is captured at the setup edge so it is stable for the whole
    // access phase, then dropped so it never lingers past the transfer.
    prdata_d  = (setup_ph && !pwrite && !addr_err) ? rdata : '0;
    pslverr_d = setup_ph ? (pwrite ? wr_err : addr_err) : 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en_q  <= 1'b0;
      ctrl_per_q <= 1'b0;
      ctrl_irq_q <= 1'b0;
      load_q     <= '0;
      done_q     <= 1'b0;
      exp_q      <= '0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
    end else begin
      ctrl_en_q  <= ctrl_en_d;
      ctrl_per_q <= ctrl_per_d;
      ctrl_irq_q <= ctrl_irq_d;
      load_q     <= load_d;
      done_q     <= done_d;
      exp_q      <= exp_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
    end
  end

  assign prdata        = prdata_q;
  assign pready        = 1'b1;
  assign pslverr       = pslverr_q;
  assign ctrl_periodic = ctrl_per_q;
  assign ctrl_irq_en   = ctrl_irq_q;
  assign load_val      = load_q;
  assign done          = done_q;

endmodule

// File: rtl/apb_timer_ctrl.sv
// apb_timer_ctrl
//   APB3-programmed sequencer for a down-counter datapath: arms the counter,
//   watches its expiry, optionally auto-reloads and raises a maskable level irq.
//   Ports:
//     clk, reset (async, active-low)
//     psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr - APB3 slave
//     cnt_en    - counter run enable (high in ARM and RUN)
//     cnt_load  - reload value, captured from LOAD on entry to ARM
//     cnt_count - live counter value (readable through COUNT)
//     cnt_done  - counter expiry, rising-edge detected
//     irq       - DONE & IRQ_EN, registered
module apb_timer_ctrl #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              cnt_en,
  output logic [CNT_W-1:0]  cnt_load,
  input  logic [CNT_W-1:0]  cnt_count,
  input  logic              cnt_done,
  output logic              irq
);
  import apb_timer_pkg::*;

  tmr_state_e       state_q, state_d;
  logic             done_smp_q, done_smp_d;
  logic             done_smp2_q, done_smp2_d;
  logic [CNT_W-1:0] cnt_load_q, cnt_load_d;
  logic             irq_q, irq_d;

  logic             done_rise;
  logic             expire;
  logic             zero_load;
  logic             set_done;
  logic             inc_exp;
  logic             clr_en;

  logic             ctrl_periodic;
  logic             ctrl_irq_en;
  logic [CNT_W-1:0] load_val;
  logic             done_flag;
  logic             wr_en_set;
  logic             wr_en_clr;

  apb_timer_regfile #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_regfile (
    .clk           (clk),
    .reset         (reset),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pready        (pready),
    .pslverr       (pslverr),
    .cnt_count     (cnt_count),
    .set_done      (set_done),
    .inc_exp       (inc_exp),
    .clr_en        (clr_en),
    .ctrl_periodic (ctrl_periodic),
    .ctrl_irq_en   (ctrl_irq_en),
    .load_val      (load_val),
    .done          (done_flag),
    .wr_en_set     (wr_en_set),
    .wr_en_clr     (wr_en_clr)
  );

  // cnt_done is sampled once and then edge-detected against the previous
  // sample, so the FSM reacts one edge after the expiry is first seen.
  always_comb begin
    done_smp_d  = cnt_done;
    done_smp2_d = done_smp_q;
    done_rise   = done_smp_q && !done_smp2_q;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    expire    = 1'b0;
    zero_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_en_set) begin
          if (load_val == '0) begin
            zero_load = 1'b1;
          end else begin
            state_d = ST_ARM;
          end
        end
      end
      ST_ARM:    state_d = ST_RUN;
      ST_RUN: begin
        if (done_rise) begin
          expire  = 1'b1;
          state_d = ctrl_periodic ? ST_RELOAD : ST_IDLE;
        end
      end
      ST_RELOAD: state_d = ST_ARM;
      default:   state_d = ST_IDLE;
    endcase
    // Software abort beats everything, including a coincident expiry
    if (wr_en_clr) begin
      state_d = ST_IDLE;
      expire  = 1'b0;
    end
  end

  // Outputs and status side effects
  always_comb begin
    cnt_en     = (state_q == ST_ARM) || (state_q == ST_RUN);
    set_done   = expire || zero_load;
    inc_exp    = expire;
    clr_en     = zero_load || (expire && !ctrl_periodic);
    // ARM lasts exactly one cycle, so state_d == ARM marks ARM entry
    cnt_load_d = (state_d == ST_ARM) ? load_val : cnt_load_q;
    irq_d      = done_flag && ctrl_irq_en;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      done_smp_q  <= 1'b0;
      done_smp2_q <= 1'b0;
      cnt_load_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_smp_q  <= done_smp_d;
      done_smp2_q <= done_smp2_d;
      cnt_load_q  <= cnt_load_d;
      irq_q       <= irq_d;
    end
  end

  assign cnt_load = cnt_load_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_apb_timer_ctrl.sv
// tb_apb_timer_ctrl
//   Directed self-checking bench for apb_timer_ctrl. APB response
//   expectations are queued when a transfer is issued and compared when the
//   DUT presents its response in the access phase.
module tb_apb_timer_ctrl;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] A_CTRL   = 8'h00;
  localparam logic [ADDR_W-1:0] A_LOAD   = 8'h04;
  localparam logic [ADDR_W-1:0] A_COUNT  = 8'h08;
  localparam logic [ADDR_W-1:0] A_STATUS = 8'h0C;

  logic              clk;
  logic              reset;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic              cnt_en;
  logic [CNT_W-1:0]  cnt_load;
  logic [CNT_W-1:0]  cnt_count;
  logic              cnt_done;
  logic              irq;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  logic [31:0] data_q[$];
  logic        err_q[$];

  apb_timer_ctrl #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .cnt_en    (cnt_en),
    .cnt_load  (cnt_load),
    .cnt_count (cnt_count),
    .cnt_done  (cnt_done),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One APB transfer; returns 1 time unit after the access (commit) edge.
  task automatic apb_xfer(input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input string tag);
    string       t;
    logic [31:0] d;
    logic        e;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    tag_q.push_back(tag);
    data_q.push_back(exp_rd);
    err_q.push_back(exp_err);
    tick(1);
    penable = 1'b1;
    #2;
    t = tag_q.pop_front();
    d = data_q.pop_front();
    e = err_q.pop_front();
    chk({t, ".pslverr"}, 32'(pslverr), 32'(e));
    if (!wr) chk({t, ".prdata"}, prdata, d);
    tick(1);
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                    input logic exp_err, input string tag);
    apb_xfer(1'b1, a, d, 32'h0, exp_err, tag);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp,
                    input logic exp_err, input string tag);
    apb_xfer(1'b0, a, 32'h0, exp, exp_err, tag);
  endtask

  initial begin
    reset     = 1'b1;
    psel      = 1'b0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = '0;
    pwdata    = '0;
    cnt_count = '0;
    cnt_done  = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("rst.cnt_en", 32'(cnt_en), 32'h0);
    chk("rst.cnt_load", 32'(cnt_load), 32'h0);
    chk("rst.irq", 32'(irq), 32'h0);
    chk("rst.prdata", prdata, 32'h0);
    chk("rst.pslverr", 32'(pslverr), 32'h0);
    chk("rst.pready", 32'(pready), 32'h1);
    tick(2);
    reset = 1'b1;
    tick(1);
    rd(A_CTRL, 32'h0, 1'b0, "rst.ctrl");
    rd(A_LOAD, 32'h0, 1'b0, "rst.load");
    rd(A_STATUS, 32'h0, 1'b0, "rst.status");

    // One-shot
    wr(A_LOAD, 32'd5, 1'b0, "os.wload");
    wr(A_CTRL, 32'h5, 1'b0, "os.wctrl");
    chk("os.arm_en", 32'(cnt_en), 32'h1);
    chk("os.arm_load", 32'(cnt_load), 32'd5);
    tick(1);
    cnt_count = 16'd3;
    rd(A_COUNT, 32'd3, 1'b0, "os.count");
    cnt_done = 1'b1;
    tick(1);
    cnt_done = 1'b0;
    chk("os.en_at_m", 32'(cnt_en), 32'h1);
    tick(1);
    chk("os.en_m1", 32'(cnt_en), 32'h0);
    chk("os.irq_m1", 32'(irq), 32'h0);
    tick(1);
    chk("os.irq_m2", 32'(irq), 32'h1);
    rd(A_CTRL, 32'h4, 1'b0, "os.ctrl");
    rd(A_STATUS, 32'h0000_0101, 1'b0, "os.status");
    wr(A_STATUS, 32'h8000_0001, 1'b0, "os.clr");
    tick(1);
    chk("os.irq_clr", 32'(irq), 32'h0);
    rd(A_STATUS, 32'h0, 1'b0, "os.status_clr");

    // Periodic, with a LOAD rewrite during RUN applied at the next ARM only
    wr(A_LOAD, 32'd3, 1'b0, "per.wload");
    wr(A_CTRL, 32'h7, 1'b0, "per.wctrl");
    chk("per.arm_en", 32'(cnt_en), 32'h1);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        wr(A_LOAD, 32'd9, 1'b0, "per.wload_run");
        chk("per.load_hold", 32'(cnt_load), 32'd3);
      end
      cnt_done = 1'b1;
      tick(1);
      cnt_done = 1'b0;
      tick(1);
      chk("per.gap", 32'(cnt_en), 32'h0);
      tick(1);
      chk("per.rearm", 32'(cnt_en), 32'h1);
      chk("per.cnt_load", 32'(cnt_load), (i == 2) ? 32'd9 : 32'd3);
      tick(1);
    end
    rd(A_STATUS, 32'h0000_0301, 1'b0, "per.status");
    wr(A_CTRL, 32'h6, 1'b0, "per.stop");
    chk("per.stop_en", 32'(cnt_en), 32'h0);
    wr(A_STATUS, 32'h8000_0001, 1'b0, "per.clr");
    tick(1);
    chk("per.irq_clr", 32'(irq), 32'h0);

    // Plain abort
    wr(A_CTRL, 32'h1, 1'b0, "ab.start");
    tick(1);
    chk("ab.run_en", 32'(cnt_en), 32'h1);
    wr(A_CTRL, 32'h0, 1'b0, "ab.stop");
    chk("ab.en_low", 32'(cnt_en), 32'h0);
    tick(2);
    rd(A_STATUS, 32'h0, 1'b0, "ab.status");
    chk("ab.irq", 32'(irq), 32'h0);

    // Abort coincident with an expiry: abort wins, DONE not set
    wr(A_CTRL, 32'h5, 1'b0, "abx.start");
    tick(1);
    cnt_done = 1'b1;
    wr(A_CTRL, 32'h4, 1'b0, "abx.stop");
    cnt_done = 1'b0;
    chk("abx.en_low", 32'(cnt_en), 32'h0);
    tick(2);
    chk("abx.irq", 32'(irq), 32'h0);
    rd(A_STATUS, 32'h0, 1'b0, "abx.status");

    // Error responses
    rd(8'h10, 32'h0, 1'b1, "err.rd10");
    wr(A_COUNT, 32'h1, 1'b1, "err.wcount");
    chk("err.wcount_en", 32'(cnt_en), 32'h0);
    wr(8'h06, 32'h1, 1'b1, "err.w6");
    wr(8'h10, 32'h1, 1'b1, "err.w10");
    chk("err.w10_en", 32'(cnt_en), 32'h0);
    rd(A_LOAD, 32'd9, 1'b0, "err.load");
    rd(A_CTRL, 32'h4, 1'b0, "err.ctrl");
    cnt_count = 16'hBEEF;
    rd(A_COUNT, 32'h0000_BEEF, 1'b0, "err.count");

    // LOAD == 0 with EN=1: DONE set, no ARM
    wr(A_LOAD, 32'd0, 1'b0, "zl.wload");
    wr(A_CTRL, 32'h5, 1'b0, "zl.wctrl");
    chk("zl.no_arm", 32'(cnt_en), 32'h0);
    tick(1);
    chk("zl.no_arm2", 32'(cnt_en), 32'h0);
    rd(A_STATUS, 32'h0000_0001, 1'b0, "zl.status");
    rd(A_CTRL, 32'h4, 1'b0, "zl.ctrl");
    chk("zl.irq", 32'(irq), 32'h1);
    wr(A_STATUS, 32'h1, 1'b0, "zl.clr");
    tick(1);

    // DONE W1C coincident with an expiry: set wins
    wr(A_LOAD, 32'd4, 1'b0, "w1c.wload");
    wr(A_CTRL, 32'h1, 1'b0, "w1c.wctrl");
    tick(1);
    cnt_done = 1'b1;
    wr(A_STATUS, 32'h1, 1'b0, "w1c.clr");
    cnt_done = 1'b0;
    rd(A_STATUS, 32'h0000_0101, 1'b0, "w1c.status");
    chk("w1c.en", 32'(cnt_en), 32'h0);
    rd(A_CTRL, 32'h0, 1'b0, "w1c.ctrl");

    // EXP_CNT clear coincident with an expiry: count becomes 1
    wr(A_CTRL, 32'h3, 1'b0, "expc.wctrl");
    tick(1);
    cnt_done = 1'b1;
    wr(A_STATUS, 32'h8000_0000, 1'b0, "expc.clr");
    cnt_done = 1'b0;
    rd(A_STATUS, 32'h0000_0101, 1'b0, "expc.status");

    // Saturation after 260 more expiries
    for (int i = 0; i < 260; i++) begin
      cnt_done = 1'b1;
      tick(1);
      cnt_done = 1'b0;
      tick(3);
    end
    rd(A_STATUS, 32'h0000_FF01, 1'b0, "sat.status");

    // Asynchronous reset during RUN
    wr(A_CTRL, 32'h7, 1'b0, "rr.wctrl");
    tick(1);
    chk("rr.pre_en", 32'(cnt_en), 32'h1);
    chk("rr.pre_irq", 32'(irq), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rr.cnt_en", 32'(cnt_en), 32'h0);
    chk("rr.irq", 32'(irq), 32'h0);
    chk("rr.cnt_load", 32'(cnt_load), 32'h0);
    chk("rr.prdata", prdata, 32'h0);
    chk("rr.pslverr", 32'(pslverr), 32'h0);
    #1 reset = 1'b1;
    tick(3);
    chk("rr.idle_en", 32'(cnt_en), 32'h0);
    rd(A_CTRL, 32'h0, 1'b0, "rr.ctrl");
    rd(A_STATUS, 32'h0, 1'b0, "rr.status");
    rd(A_LOAD, 32'h0, 1'b0, "rr.load");
    chk("rr.idle_en2", 32'(cnt_en), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
